// File: rtl/eth_frame_loop_report.sv
// Loop-path report stage: forwards compare-stage bytes with one cycle of latency, and at every
// end of frame produces a held match report plus saturating per-script statistics.
module eth_frame_loop_report #(
    parameter int C_NUM_SCRIPTS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear_counters,
    input  logic [7:0]                    s_axis_tdata,
    input  logic [17*C_NUM_SCRIPTS:0]     s_axis_tuser,
    input  logic                          s_axis_tlast,
    input  logic                          s_axis_tvalid,
    output logic [7:0]                    m_axis_tdata,
    output logic [16*C_NUM_SCRIPTS-1:0]   m_axis_tuser,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tvalid,
    output logic                          report_valid,
    input  logic                          report_ready,
    output logic [C_NUM_SCRIPTS-1:0]      report_match,
    output logic                          report_fcs_invalid,
    output logic [15:0]                   report_length,
    output logic [32*C_NUM_SCRIPTS-1:0]   match_count,
    output logic [31:0]                   frame_count,
    output logic [31:0]                   drop_count
);
    localparam int N = C_NUM_SCRIPTS;
    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [7:0]        tdata_q;
    logic [16*N-1:0]   tuser_q, tuser_d;
    logic              tlast_q, tvalid_q;
    logic [15:0]       len_q, len_d, frame_len;
    logic [0:0]        state_q, state_d;
    logic [N-1:0]      rpt_match_q, frame_match;
    logic              rpt_fcs_q;
    logic [15:0]       rpt_len_q;
    logic [32*N-1:0]   match_cnt_q, match_cnt_d;
    logic [31:0]       frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;
    logic              eof, rpt_load, rpt_drop;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign eof       = s_axis_tvalid & s_axis_tlast;
    assign rpt_load  = eof & ((state_q == S_EMPTY) | report_ready);
    assign rpt_drop  = eof & (state_q == S_FULL) & ~report_ready;
    assign frame_len = (len_q == 16'hFFFF) ? 16'hFFFF : len_q + 16'd1;

    // A bad FCS masks every script's match for the frame.
    always_comb begin
        frame_match = '0;
        tuser_d     = '0;
        for (int i = 0; i < N; i++) begin
            frame_match[i]      = s_axis_tuser[17*i+1] & ~s_axis_tuser[0];
            tuser_d[16*i +: 16] = s_axis_tuser[17*i+2 +: 16];
        end
    end

    always_comb begin
        len_d = len_q;
        if (s_axis_tvalid) begin
            if (s_axis_tlast)
                len_d = '0;
            else if (len_q != 16'hFFFF)
                len_d = len_q + 16'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rpt_load)
            state_d = S_FULL;
        else if ((state_q == S_FULL) && report_ready)
            state_d = S_EMPTY;
    end

    // Counters count at EOF regardless of the handshake; a clear overrides a same-cycle increment.
    always_comb begin
        match_cnt_d = match_cnt_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (eof) begin
            frame_cnt_d = sat_inc(frame_cnt_q);
            for (int i = 0; i < N; i++)
                if (frame_match[i])
                    match_cnt_d[32*i +: 32] = sat_inc(match_cnt_q[32*i +: 32]);
        end
        if (rpt_drop)
            drop_cnt_d = sat_inc(drop_cnt_q);
        if (clear_counters) begin
            match_cnt_d = '0;
            frame_cnt_d = '0;
            drop_cnt_d  = '0;
        end
    end

    // NOTE: all state updates are non-blocking so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            tdata_q     <= '0;
            tuser_q     <= '0;
            tlast_q     <= 1'b0;
            tvalid_q    <= 1'b0;
            len_q       <= '0;
            state_q     <= S_EMPTY;
            rpt_match_q <= '0;
            rpt_fcs_q   <= 1'b0;
            rpt_len_q   <= '0;
            match_cnt_q <= '0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            tdata_q     <= s_axis_tdata;
            tuser_q     <= tuser_d;
            tlast_q     <= s_axis_tlast;
            tvalid_q    <= s_axis_tvalid;
            len_q       <= len_d;
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            if (rpt_load) begin
                rpt_match_q <= frame_match;
                rpt_fcs_q   <= s_axis_tuser[0];
                rpt_len_q   <= frame_len;
            end
        end
    end

    assign m_axis_tdata       = tdata_q;
    assign m_axis_tuser       = tuser_q;
    assign m_axis_tlast       = tlast_q;
    assign m_axis_tvalid      = tvalid_q;
    assign report_valid       = (state_q == S_FULL);
    assign report_match       = rpt_match_q;
    assign report_fcs_invalid = rpt_fcs_q;
    assign report_length      = rpt_len_q;
    assign match_count        = match_cnt_q;
    assign frame_count        = frame_cnt_q;
    assign drop_count         = drop_cnt_q;
endmodule

// File: tb/tb_eth_frame_loop_report.sv
// Self-checking bench for eth_frame_loop_report: scenario tasks plus a per-edge monitor with a
// scoreboard of expected reports, popped when a report handshake completes.
module tb_eth_frame_loop_report;
    localparam int N = 4;

    typedef struct {
        logic [N-1:0] match;
        logic         fcs;
        logic [15:0]  len;
    } report_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clear_counters = 1'b0;
    logic [7:0]        s_axis_tdata = '0;
    logic [17*N:0]     s_axis_tuser = '0;
    logic              s_axis_tlast = 1'b0;
    logic              s_axis_tvalid = 1'b0;
    logic [7:0]        m_axis_tdata;
    logic [16*N-1:0]   m_axis_tuser;
    logic              m_axis_tlast;
    logic              m_axis_tvalid;
    logic              report_valid;
    logic              report_ready = 1'b1;
    logic [N-1:0]      report_match;
    logic              report_fcs_invalid;
    logic [15:0]       report_length;
    logic [32*N-1:0]   match_count;
    logic [31:0]       frame_count;
    logic [31:0]       drop_count;

    int total = 0;
    int bad   = 0;

    eth_frame_loop_report #(.C_NUM_SCRIPTS(N)) dut (
        .clk(clk), .rst(rst), .clear_counters(clear_counters),
        .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
        .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
        .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
        .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
        .report_valid(report_valid), .report_ready(report_ready),
        .report_match(report_match), .report_fcs_invalid(report_fcs_invalid),
        .report_length(report_length), .match_count(match_count),
        .frame_count(frame_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Reference model state, advanced at every rising edge from the sampled inputs.
    report_t         exp_q[$];
    logic            m_full = 1'b0;
    int              m_len = 0;
    logic            started = 1'b0;
    logic [7:0]      prev_tdata = '0;
    logic [16*N-1:0] prev_tuser = '0;
    logic            prev_tlast = 1'b0;
    logic            prev_tvalid = 1'b0;

    always @(posedge clk) begin
        report_t r;
        report_t e;
        logic [N-1:0] mask;
        if (rst) begin
            started = 1'b1;
            m_full  = 1'b0;
            m_len   = 0;
            exp_q.delete();
            prev_tdata  = '0;
            prev_tuser  = '0;
            prev_tlast  = 1'b0;
            prev_tvalid = 1'b0;
        end else if (started) begin
            total++;
            if ({m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tvalid} !==
                {prev_tdata, prev_tuser, prev_tlast, prev_tvalid}) begin
                bad++;
                $display("FAIL passthrough: got d=%h u=%h l=%b v=%b want d=%h u=%h l=%b v=%b",
                         m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tvalid,
                         prev_tdata, prev_tuser, prev_tlast, prev_tvalid);
            end
            total++;
            if (report_valid !== m_full) begin
                bad++;
                $display("FAIL report_valid_track: got %b want %b", report_valid, m_full);
            end
            if (m_full && report_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_underflow: got handshake want empty scoreboard");
                end else begin
                    e = exp_q.pop_front();
                    if (report_match !== e.match || report_fcs_invalid !== e.fcs ||
                        report_length !== e.len) begin
                        bad++;
                        $display("FAIL sb_report: got m=%b f=%b len=%0d want m=%b f=%b len=%0d",
                                 report_match, report_fcs_invalid, report_length,
                                 e.match, e.fcs, e.len);
                    end
                end
                m_full = 1'b0;
            end
            if (s_axis_tvalid && s_axis_tlast) begin
                for (int i = 0; i < N; i++) mask[i] = s_axis_tuser[17*i+1] & ~s_axis_tuser[0];
                if (!m_full || report_ready) begin
                    r.match = mask;
                    r.fcs   = s_axis_tuser[0];
                    r.len   = (m_len >= 65535) ? 16'hFFFF : 16'(m_len + 1);
                    exp_q.push_back(r);
                    m_full = 1'b1;
                end
                m_len = 0;
            end else if (s_axis_tvalid) begin
                if (m_len < 65535) m_len++;
            end
            prev_tdata  = s_axis_tdata;
            for (int i = 0; i < N; i++) prev_tuser[16*i +: 16] = s_axis_tuser[17*i+2 +: 16];
            prev_tlast  = s_axis_tlast;
            prev_tvalid = s_axis_tvalid;
        end
    end

    function automatic logic [17*N:0] mk_tuser(input logic [N-1:0] m, input logic fcs);
        logic [17*N:0] u;
        u[0] = fcs;
        for (int i = 0; i < N; i++) begin
            u[17*i+1]       = m[i];
            u[17*i+2 +: 16] = 16'($urandom);
        end
        return u;
    endfunction

    task automatic send_beat(input logic [7:0] d, input logic last, input logic [N-1:0] m,
                             input logic fcs);
        @(negedge clk);
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = last;
        s_axis_tuser  = mk_tuser(last ? m : '0, fcs);
    endtask

    task automatic send_frame(input int n, input logic [N-1:0] m, input logic fcs);
        for (int i = 0; i < n; i++)
            send_beat(8'($urandom), (i == n - 1), m, fcs);
    endtask

    task automatic step();
        @(negedge clk);
        s_axis_tvalid  = 1'b0;
        s_axis_tlast   = 1'b0;
        s_axis_tuser   = '0;
        clear_counters = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tvalid, report_valid, report_match,
             report_fcs_invalid, report_length, match_count, frame_count, drop_count} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%b frames=%0d want all zero",
                     report_valid, frame_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        report_ready = 1'b1;
        send_frame(64, 4'b0101, 1'b0);
        step();
        total++;
        if (report_valid !== 1'b1 || report_match !== 4'b0101 || report_length !== 16'd64) begin
            bad++;
            $display("FAIL basic_report: got v=%b m=%b len=%0d want v=1 m=0101 len=64",
                     report_valid, report_match, report_length);
        end
        total++;
        if (match_count !== {32'd0, 32'd1, 32'd0, 32'd1} || frame_count !== 32'd1) begin
            bad++;
            $display("FAIL basic_counters: got mc=%h fc=%0d want mc=0/1/0/1 fc=1",
                     match_count, frame_count);
        end
        step();
        total++;
        if (report_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_pulse: got valid=%b want 0", report_valid);
        end
    endtask

    task automatic test_fcs_invalid();
        send_frame(8, 4'b1111, 1'b1);
        step();
        total++;
        if (report_match !== 4'b0000 || report_fcs_invalid !== 1'b1) begin
            bad++;
            $display("FAIL fcs_report: got m=%b f=%b want m=0000 f=1",
                     report_match, report_fcs_invalid);
        end
        total++;
        if (match_count !== {32'd0, 32'd1, 32'd0, 32'd1} || frame_count !== 32'd2) begin
            bad++;
            $display("FAIL fcs_counters: got mc=%h fc=%0d want mc=0/1/0/1 fc=2",
                     match_count, frame_count);
        end
        step();
    endtask

    task automatic test_drop();
        @(negedge clk);
        clear_counters = 1'b1;
        step();
        report_ready = 1'b0;
        send_beat(8'h11, 1'b1, 4'b0001, 1'b0);
        send_beat(8'h22, 1'b1, 4'b0010, 1'b0);
        send_beat(8'h33, 1'b1, 4'b0100, 1'b0);
        step();
        total++;
        if (report_valid !== 1'b1 || report_match !== 4'b0001 || report_length !== 16'd1) begin
            bad++;
            $display("FAIL drop_hold: got v=%b m=%b len=%0d want v=1 m=0001 len=1",
                     report_valid, report_match, report_length);
        end
        total++;
        if (drop_count !== 32'd2 || frame_count !== 32'd3) begin
            bad++;
            $display("FAIL drop_counters: got drop=%0d fc=%0d want drop=2 fc=3",
                     drop_count, frame_count);
        end
        report_ready = 1'b1;
        step();
        total++;
        if (report_valid !== 1'b0) begin
            bad++;
            $display("FAIL drop_release: got valid=%b want 0", report_valid);
        end
    endtask

    task automatic test_back_to_back();
        report_ready = 1'b0;
        send_beat(8'h44, 1'b1, 4'b0010, 1'b0);
        step();
        total++;
        if (report_valid !== 1'b1 || report_match !== 4'b0010) begin
            bad++;
            $display("FAIL b2b_first: got v=%b m=%b want v=1 m=0010", report_valid, report_match);
        end
        send_beat(8'h55, 1'b1, 4'b1000, 1'b0);
        report_ready = 1'b1;
        step();
        total++;
        if (report_valid !== 1'b1 || report_match !== 4'b1000 || drop_count !== 32'd2) begin
            bad++;
            $display("FAIL b2b_replace: got v=%b m=%b drop=%0d want v=1 m=1000 drop=2",
                     report_valid, report_match, drop_count);
        end
        step();
        total++;
        if (report_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_release: got valid=%b want 0", report_valid);
        end
    endtask

    task automatic test_saturation();
        report_ready = 1'b1;
        send_frame(70000, 4'b0000, 1'b0);
        step();
        total++;
        if (report_length !== 16'hFFFF) begin
            bad++;
            $display("FAIL sat_length: got %h want ffff", report_length);
        end
        step();
        send_frame(10, 4'b0000, 1'b0);
        step();
        total++;
        if (report_length !== 16'd10) begin
            bad++;
            $display("FAIL after_sat_length: got %0d want 10", report_length);
        end
        step();
    endtask

    task automatic test_clear();
        send_frame(4, 4'b0001, 1'b0);
        clear_counters = 1'b1;
        step();
        total++;
        if (match_count !== '0 || frame_count !== 32'd0 || drop_count !== 32'd0) begin
            bad++;
            $display("FAIL clear_wins: got mc=%h fc=%0d drop=%0d want all 0",
                     match_count, frame_count, drop_count);
        end
        total++;
        if (report_valid !== 1'b1 || report_match !== 4'b0001 || report_length !== 16'd4) begin
            bad++;
            $display("FAIL clear_report: got v=%b m=%b len=%0d want v=1 m=0001 len=4",
                     report_valid, report_match, report_length);
        end
        step();
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 5; i++) send_beat(8'(i), 1'b0, '0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        s_axis_tvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (match_count !== '0 || frame_count !== 32'd0 || drop_count !== 32'd0 ||
            report_valid !== 1'b0) begin
            bad++;
            $display("FAIL midreset_state: got fc=%0d v=%b want fc=0 v=0",
                     frame_count, report_valid);
        end
        send_frame(3, 4'b0000, 1'b0);
        step();
        total++;
        if (report_length !== 16'd3 || frame_count !== 32'd1) begin
            bad++;
            $display("FAIL midreset_length: got len=%0d fc=%0d want len=3 fc=1",
                     report_length, frame_count);
        end
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fcs_invalid();
        test_drop();
        test_back_to_back();
        test_saturation();
        test_clear();
        test_reset_midframe();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
